reserved_slot_controller: RTL and testbench
===========================================

RESERVED_SLOT_CONTROLLER -- requirements
Module: reserved_slot_controller

Interface
REQ-001 SHALL have parameter N_SLOTS, default `parking_slots, the number of reserved slots (one per flat, flats 1..N_SLOTS).
REQ-002 SHALL have parameter FW, default 8, the flat-number width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en_req, input, 1, entry-gate request, held until en_ack.
REQ-006 SHALL have ports en_flat (input, FW, entry flat number) and en_pwd (input, 1, PwD permit on vehicle).
REQ-007 SHALL have port en_ack, output, 1, one-cycle entry acknowledge.
REQ-008 SHALL have ports ex_req (input, 1), ex_flat (input, FW), ex_ack (output, 1) for the exit gate, with the same handshake as entry.
REQ-009 SHALL have port rsp_valid, output, 1, one-cycle response strobe coincident with the ack.
REQ-010 SHALL have ports rsp_ok (output, 1, 1=gate may open), rsp_code (output, 2, 0 OK, 1 CONFLICT, 2 BAD_FLAT, 3 NOT_PWD) and rsp_src (output, 1, 0 entry, 1 exit).
REQ-011 SHALL have ports occ_map (output, N_SLOTS, bit k-1 = flat k occupied), occ_count (output, $clog2(N_SLOTS+1), set bits in occ_map) and full (output, 1, occ_count==N_SLOTS).

Function
REQ-012 SHALL use an FSM IDLE->CHECK->RESP->IDLE, one cycle per state.
REQ-013 In IDLE the FSM SHALL pick a winner among asserted requests, latch flat/pwd/src at the edge and go to CHECK; with no request it SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: on a simultaneous request the source not served last wins; a lone request always wins; pointer updates only on a grant.
REQ-015 Entry in CHECK: flat 0 or >N_SLOTS -> BAD_FLAT; slot already occupied -> CONFLICT; otherwise OK and the bit is set at the CHECK->RESP edge.
REQ-016 Exit in CHECK: bad flat -> BAD_FLAT; slot free -> CONFLICT; otherwise OK and the bit is cleared at the CHECK->RESP edge.
REQ-017 Checks SHALL be evaluated in the order BAD_FLAT, NOT_PWD (REQ-026), CONFLICT; a non-OK result SHALL leave occ_map unchanged.
REQ-018 In RESP the ack of the served source, rsp_valid, rsp_ok, rsp_code and rsp_src SHALL all be high/valid for exactly one cycle; latency is req sampled at edge t -> ack during cycle t+2.
REQ-019 occ_map, occ_count and full SHALL reflect the update in the RESP cycle and stay stable otherwise.
REQ-020 A req still high in the IDLE cycle after its ack SHALL be treated as a new request; the requester drops req after ack.
REQ-021 Throughput SHALL be one transaction per 3 cycles; the non-winning request waits with no ack.
REQ-022 rsp_code/rsp_ok/rsp_src SHALL hold their last values outside RESP; only rsp_valid qualifies them.

Reset
REQ-023 On rst: FSM to IDLE, occ_map 0, occ_count 0, full 0, en_ack/ex_ack/rsp_valid/rsp_ok 0, rsp_code 0, rsp_src 0, RR pointer favours entry.
REQ-024 A reset during CHECK or RESP SHALL abort the transaction with no ack, and no occ_map update SHALL survive.

Configuration
REQ-025 Macro RESERVED_PWD_CHECK_EN SHALL select the PwD check.
REQ-026 With the macro defined, an entry with en_pwd=0 SHALL get NOT_PWD and make no map change.
REQ-027 Without the macro, en_pwd SHALL be ignored and code 3 SHALL never be issued.

Structure
REQ-028 The shared package rsv_pkg SHALL hold the FSM state typedef and the rsp_code constants (RSP_OK, RSP_CONFLICT, RSP_BAD_FLAT, RSP_NOT_PWD).
REQ-029 Arbitration SHALL be in sub-module rsv_rr_arb (2 requests, update strobe, one-hot grant); the FSM and map SHALL be in the top module.

Verification (N_SLOTS=8, macro defined)
REQ-030 The bench SHALL cover: after reset, en_req with flat 3 and pwd=1 -> en_ack at t+2, rsp_ok=1, code 0, occ_map=0x04, occ_count=1.
REQ-031 The bench SHALL cover: flat 3 occupied, en_req with flat 3 -> CONFLICT, map unchanged; then ex_req with flat 3 -> OK, map 0x00; then ex_req with flat 3 again -> CONFLICT.
REQ-032 The bench SHALL cover: en_req and ex_req raised in the same cycle with last grant=entry -> exit served first, entry acked 3 cycles later.
REQ-033 The bench SHALL cover: en_req with flat 0 and with flat 9 -> BAD_FLAT; en_req with flat 5 and pwd=0 -> NOT_PWD (code 0 with the macro undefined).
REQ-034 The bench SHALL cover: fill flats 1..8 -> full=1, occ_count=8; then assert rst during CHECK of an exit -> no ex_ack, map 0x00, full=0.

Source files
------------

// File: rtl/rsv_pkg.sv
// rsv_pkg -- shared types and constants for the reserved parking slot
// controller.
//   state_t      : controller FSM state encoding
//   RSP_*        : response codes carried on rsp_code
//   SRC_*        : request source encoding (rsp_src, arbiter index)
// `PARKING_SLOTS supplies the default slot count. It falls back to 8 when
// the build does not define it.

`ifndef PARKING_SLOTS
`define PARKING_SLOTS 8
`endif

package rsv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] RSP_OK       = 2'd0;
    localparam logic [1:0] RSP_CONFLICT = 2'd1;
    localparam logic [1:0] RSP_BAD_FLAT = 2'd2;
    localparam logic [1:0] RSP_NOT_PWD  = 2'd3;

    localparam logic SRC_ENTRY = 1'b0;
    localparam logic SRC_EXIT  = 1'b1;

endpackage

// File: rtl/rsv_rr_arb.sv
// rsv_rr_arb -- two-way round-robin arbiter for the entry/exit gates.
//   clk, rst : clock, asynchronous active-high reset
//   req_i[0] : entry request      req_i[1] : exit request
//   upd_i    : strobe; the current grant is recorded as "served last"
//   gnt_o    : one-hot grant, combinational from req_i and history
// After reset the exit side counts as served last, so a simultaneous
// request goes to entry first.

module rsv_rr_arb
    import rsv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;   // source served most recently

    always_comb begin
        gnt_o = req_i;
        if (req_i[0] && req_i[1]) begin
            gnt_o = (last_q == SRC_EXIT) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (upd_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1] ? SRC_EXIT : SRC_ENTRY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= SRC_EXIT;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/reserved_slot_controller.sv
// reserved_slot_controller -- reserved parking slot bookkeeping for one
// entry gate and one exit gate. Each flat 1..N_SLOTS owns one slot.
//   clk, rst            : clock, asynchronous active-high reset
//   en_req/en_flat/en_pwd/en_ack : entry gate handshake (req held to ack)
//   ex_req/ex_flat/ex_ack        : exit gate handshake
//   rsp_valid           : one-cycle strobe alongside the ack
//   rsp_ok/rsp_code/rsp_src : result, held between strobes
//   occ_map/occ_count/full  : slot occupancy
// Each transaction takes IDLE -> CHECK -> RESP, which is one every 3 cycles.
// Optional build macro RESERVED_PWD_CHECK_EN: when it is defined, an entry
// without a PwD permit is refused with RSP_NOT_PWD.

module reserved_slot_controller
    import rsv_pkg::*;
#(
    parameter int N_SLOTS = `PARKING_SLOTS,
    parameter int FW      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_req,
    input  logic [FW-1:0]                en_flat,
    input  logic                         en_pwd,
    output logic                         en_ack,
    input  logic                         ex_req,
    input  logic [FW-1:0]                ex_flat,
    output logic                         ex_ack,
    output logic                         rsp_valid,
    output logic                         rsp_ok,
    output logic [1:0]                   rsp_code,
    output logic                         rsp_src,
    output logic [N_SLOTS-1:0]           occ_map,
    output logic [$clog2(N_SLOTS+1)-1:0] occ_count,
    output logic                         full
);

    localparam int CW = $clog2(N_SLOTS+1);

    state_t               state_q, state_d;
    logic [FW-1:0]        flat_q, flat_d;
    logic                 src_q, src_d;
    logic [N_SLOTS-1:0]   map_q, map_d;
    logic                 en_ack_q, en_ack_d;
    logic                 ex_ack_q, ex_ack_d;
    logic                 valid_q, valid_d;
    logic                 ok_q, ok_d;
    logic [1:0]           code_q, code_d;
    logic                 rsrc_q, rsrc_d;

    logic [1:0]           gnt;
    logic                 upd;
    logic [N_SLOTS-1:0]   mask;
    logic                 bad_flat;
    logic                 hit;
    logic                 pwd_fail;
    logic [1:0]           chk_code;
    logic [CW-1:0]        cnt;

`ifdef RESERVED_PWD_CHECK_EN
    logic pwd_q, pwd_d;
    assign pwd_fail = (src_q == SRC_ENTRY) && !pwd_q;
`else
    logic unused_pwd;
    assign unused_pwd = en_pwd;
    assign pwd_fail   = 1'b0;
`endif

    rsv_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({ex_req, en_req}),
        .upd_i (upd),
        .gnt_o (gnt)
    );

    // Slot decode of the latched flat. The range test is done at 32 bits so
    // an out-of-range flat cannot alias onto a valid slot.
    always_comb begin
        bad_flat = (32'(flat_q) == 32'd0) || (32'(flat_q) > 32'(N_SLOTS));
        mask     = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            mask[k] = (32'(flat_q) == 32'(k + 1));
        end
        hit = |(map_q & mask);
    end

    // Check priority: BAD_FLAT, then NOT_PWD, then CONFLICT.
    always_comb begin
        chk_code = RSP_OK;
        if (bad_flat)                        chk_code = RSP_BAD_FLAT;
        else if (pwd_fail)                   chk_code = RSP_NOT_PWD;
        else if ((src_q == SRC_ENTRY) && hit)  chk_code = RSP_CONFLICT;
        else if ((src_q == SRC_EXIT) && !hit)  chk_code = RSP_CONFLICT;
    end

    always_comb begin
        state_d  = state_q;
        flat_d   = flat_q;
        src_d    = src_q;
        map_d    = map_q;
        en_ack_d = 1'b0;
        ex_ack_d = 1'b0;
        valid_d  = 1'b0;
        ok_d     = ok_q;
        code_d   = code_q;
        rsrc_d   = rsrc_q;
        upd      = 1'b0;
`ifdef RESERVED_PWD_CHECK_EN
        pwd_d    = pwd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt != 2'b00) begin
                    upd     = 1'b1;
                    state_d = S_CHECK;
                    src_d   = gnt[1] ? SRC_EXIT : SRC_ENTRY;
                    flat_d  = gnt[1] ? ex_flat : en_flat;
`ifdef RESERVED_PWD_CHECK_EN
                    pwd_d   = gnt[1] ? 1'b1 : en_pwd;
`endif
                end
            end
            S_CHECK: begin
                // The result and acks are registered here, so they are
                // visible for exactly the RESP cycle.
                state_d  = S_RESP;
                code_d   = chk_code;
                ok_d     = (chk_code == RSP_OK);
                rsrc_d   = src_q;
                valid_d  = 1'b1;
                en_ack_d = (src_q == SRC_ENTRY);
                ex_ack_d = (src_q == SRC_EXIT);
                if (chk_code == RSP_OK) begin
                    map_d = (src_q == SRC_ENTRY) ? (map_q | mask) : (map_q & ~mask);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            flat_q   <= '0;
            src_q    <= SRC_ENTRY;
            map_q    <= '0;
            en_ack_q <= 1'b0;
            ex_ack_q <= 1'b0;
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            code_q   <= RSP_OK;
            rsrc_q   <= SRC_ENTRY;
`ifdef RESERVED_PWD_CHECK_EN
            pwd_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            flat_q   <= flat_d;
            src_q    <= src_d;
            map_q    <= map_d;
            en_ack_q <= en_ack_d;
            ex_ack_q <= ex_ack_d;
            valid_q  <= valid_d;
            ok_q     <= ok_d;
            code_q   <= code_d;
            rsrc_q   <= rsrc_d;
`ifdef RESERVED_PWD_CHECK_EN
            pwd_q    <= pwd_d;
`endif
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            cnt = cnt + CW'(map_q[k]);
        end
    end

    assign en_ack    = en_ack_q;
    assign ex_ack    = ex_ack_q;
    assign rsp_valid = valid_q;
    assign rsp_ok    = ok_q;
    assign rsp_code  = code_q;
    assign rsp_src   = rsrc_q;
    assign occ_map   = map_q;
    assign occ_count = cnt;
    assign full      = (32'(cnt) == 32'(N_SLOTS));

endmodule

// File: tb/tb_reserved_slot_controller.sv
// tb_reserved_slot_controller -- directed self-checking bench for
// reserved_slot_controller with N_SLOTS=8, FW=8. Expected NOT_PWD
// behaviour follows RESERVED_PWD_CHECK_EN.

module tb_reserved_slot_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_req = 1'b0;
    logic [7:0] en_flat = 8'd0;
    logic       en_pwd = 1'b0;
    logic       en_ack;
    logic       ex_req = 1'b0;
    logic [7:0] ex_flat = 8'd0;
    logic       ex_ack;
    logic       rsp_valid, rsp_ok, rsp_src;
    logic [1:0] rsp_code;
    logic [7:0] occ_map;
    logic [3:0] occ_count;
    logic       full;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    reserved_slot_controller #(.N_SLOTS(8), .FW(8)) dut (
        .clk(clk), .rst(rst),
        .en_req(en_req), .en_flat(en_flat), .en_pwd(en_pwd), .en_ack(en_ack),
        .ex_req(ex_req), .ex_flat(ex_flat), .ex_ack(ex_ack),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_code(rsp_code), .rsp_src(rsp_src),
        .occ_map(occ_map), .occ_count(occ_count), .full(full)
    );

    // Stimulus only: raises one request at a negedge, watches the negedges
    // for its ack (lat = negedges from raise to ack, -1 on timeout), drops
    // the request on the ack and waits one more cycle to land in IDLE.
    task automatic run_txn(input bit src, input logic [7:0] flat, input bit pwd,
                           output int lat, output logic [1:0] code,
                           output logic ok, output logic rs, output logic bad_strobe);
        lat = -1; code = 2'd0; ok = 1'b0; rs = 1'b0; bad_strobe = 1'b0;
        @(negedge clk);
        if (!src) begin en_req = 1'b1; en_flat = flat; en_pwd = pwd; end
        else      begin ex_req = 1'b1; ex_flat = flat; end
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (src ? ex_ack : en_ack) begin
                lat = k; code = rsp_code; ok = rsp_ok; rs = rsp_src;
                bad_strobe = !rsp_valid || (src ? en_ack : ex_ack);
            end
        end
        en_req = 1'b0; ex_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({en_ack, ex_ack, rsp_valid, rsp_ok, rsp_code, rsp_src} !== 7'b0) $display("FAIL reset_strobes got %b want 0", {en_ack, ex_ack, rsp_valid, rsp_ok, rsp_code, rsp_src});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({occ_map, occ_count, full} !== 13'b0) $display("FAIL reset_map got map=%h cnt=%0d full=%b want 0", occ_map, occ_count, full);
        else n_pass++;
    endtask

    task automatic test_entry_ok;
        int lat; logic [1:0] code; logic ok, rs, bs;
        run_txn(1'b0, 8'd3, 1'b1, lat, code, ok, rs, bs);
        n_total++;
        if (lat !== 2) $display("FAIL entry_latency got %0d want 2", lat); else n_pass++;
        n_total++;
        if ({ok, code, rs, bs} !== {1'b1, 2'd0, 1'b0, 1'b0}) $display("FAIL entry_rsp got ok=%b code=%0d src=%b bad=%b want 1/0/0/0", ok, code, rs, bs); else n_pass++;
        n_total++;
        if (occ_map !== 8'h04 || occ_count !== 4'd1 || full !== 1'b0) $display("FAIL entry_map got %h/%0d/%b want 04/1/0", occ_map, occ_count, full); else n_pass++;
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_ok !== 1'b1 || rsp_code !== 2'd0 || en_ack !== 1'b0) $display("FAIL entry_hold got v=%b ok=%b code=%0d ack=%b want 0/1/0/0", rsp_valid, rsp_ok, rsp_code, en_ack); else n_pass++;
    endtask

    task automatic test_conflict;
        int lat; logic [1:0] code; logic ok, rs, bs;
        run_txn(1'b0, 8'd3, 1'b1, lat, code, ok, rs, bs);
        n_total++;
        if (lat !== 2 || ok !== 1'b0 || code !== 2'd1 || occ_map !== 8'h04) $display("FAIL entry_conflict got lat=%0d ok=%b code=%0d map=%h want 2/0/1/04", lat, ok, code, occ_map); else n_pass++;
        run_txn(1'b1, 8'd3, 1'b0, lat, code, ok, rs, bs);
        n_total++;
        if (lat !== 2 || ok !== 1'b1 || code !== 2'd0 || rs !== 1'b1 || bs !== 1'b0 || occ_map !== 8'h00 || occ_count !== 4'd0) $display("FAIL exit_ok got lat=%0d ok=%b code=%0d src=%b bad=%b map=%h cnt=%0d want 2/1/0/1/0/00/0", lat, ok, code, rs, bs, occ_map, occ_count); else n_pass++;
        run_txn(1'b1, 8'd3, 1'b0, lat, code, ok, rs, bs);
        n_total++;
        if (lat !== 2 || ok !== 1'b0 || code !== 2'd1 || occ_map !== 8'h00) $display("FAIL exit_conflict got lat=%0d ok=%b code=%0d map=%h want 2/0/1/00", lat, ok, code, occ_map); else n_pass++;
    endtask

    task automatic test_round_robin;
        int lat; logic [1:0] code; logic ok, rs, bs;
        int t_ex, t_en;
        // Entry of flat 1 makes entry the last-served source.
        run_txn(1'b0, 8'd1, 1'b1, lat, code, ok, rs, bs);
        n_total++;
        if (ok !== 1'b1 || occ_map !== 8'h01) $display("FAIL rr_setup got ok=%b map=%h want 1/01", ok, occ_map); else n_pass++;
        t_ex = -1; t_en = -1;
        @(negedge clk);
        en_req = 1'b1; en_flat = 8'd2; en_pwd = 1'b1;
        ex_req = 1'b1; ex_flat = 8'd1;
        for (int k = 1; k <= 12 && t_en < 0; k++) begin
            @(negedge clk);
            if (ex_ack && t_ex < 0) begin t_ex = k; ex_req = 1'b0; end
            if (en_ack && t_en < 0) begin t_en = k; en_req = 1'b0; end
        end
        en_req = 1'b0; ex_req = 1'b0;
        @(negedge clk);
        n_total++;
        if (t_ex !== 2) $display("FAIL rr_exit_first got ex_ack at %0d want 2", t_ex); else n_pass++;
        n_total++;
        if (t_en !== 5) $display("FAIL rr_entry_second got en_ack at %0d want 5", t_en); else n_pass++;
        n_total++;
        if (occ_map !== 8'h02) $display("FAIL rr_map got %h want 02", occ_map); else n_pass++;
    endtask

    task automatic test_bad_flat_pwd;
        int lat; logic [1:0] code; logic ok, rs, bs;
        logic [1:0] exp_code; logic [7:0] exp_map;
        run_txn(1'b0, 8'd0, 1'b1, lat, code, ok, rs, bs);
        n_total++;
        if (lat !== 2 || ok !== 1'b0 || code !== 2'd2 || occ_map !== 8'h02) $display("FAIL flat0 got lat=%0d ok=%b code=%0d map=%h want 2/0/2/02", lat, ok, code, occ_map); else n_pass++;
        run_txn(1'b0, 8'd9, 1'b1, lat, code, ok, rs, bs);
        n_total++;
        if (lat !== 2 || ok !== 1'b0 || code !== 2'd2 || occ_map !== 8'h02) $display("FAIL flat9 got lat=%0d ok=%b code=%0d map=%h want 2/0/2/02", lat, ok, code, occ_map); else n_pass++;
        run_txn(1'b1, 8'd9, 1'b0, lat, code, ok, rs, bs);
        n_total++;
        if (lat !== 2 || ok !== 1'b0 || code !== 2'd2 || rs !== 1'b1) $display("FAIL exit_flat9 got lat=%0d ok=%b code=%0d src=%b want 2/0/2/1", lat, ok, code, rs); else n_pass++;
        // Bad flat outranks a missing permit.
        run_txn(1'b0, 8'd0, 1'b0, lat, code, ok, rs, bs);
        n_total++;
        if (code !== 2'd2) $display("FAIL bad_before_pwd got code=%0d want 2", code); else n_pass++;
`ifdef RESERVED_PWD_CHECK_EN
        exp_code = 2'd3; exp_map = 8'h02;
`else
        exp_code = 2'd0; exp_map = 8'h12;
`endif
        run_txn(1'b0, 8'd5, 1'b0, lat, code, ok, rs, bs);
        n_total++;
        if (lat !== 2 || code !== exp_code || ok !== (exp_code == 2'd0) || occ_map !== exp_map) $display("FAIL pwd got lat=%0d ok=%b code=%0d map=%h want 2/%b/%0d/%h", lat, ok, code, occ_map, (exp_code == 2'd0), exp_code, exp_map); else n_pass++;
    endtask

    task automatic test_full_and_abort;
        int lat; logic [1:0] code; logic ok, rs, bs;
        int acks;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int f = 1; f <= 8; f++) begin
            run_txn(1'b0, 8'(f), 1'b1, lat, code, ok, rs, bs);
            n_total++;
            if (lat !== 2 || ok !== 1'b1 || occ_count !== 4'(f)) $display("FAIL fill_%0d got lat=%0d ok=%b cnt=%0d want 2/1/%0d", f, lat, ok, occ_count, f); else n_pass++;
        end
        n_total++;
        if (occ_map !== 8'hFF || occ_count !== 4'd8 || full !== 1'b1) $display("FAIL full got map=%h cnt=%0d full=%b want FF/8/1", occ_map, occ_count, full); else n_pass++;
        // Exit of flat 4: the edge after the raise moves into CHECK, and
        // reset lands in that CHECK cycle.
        @(negedge clk);
        ex_req = 1'b1; ex_flat = 8'd4;
        @(negedge clk);
        rst = 1'b1;
        ex_req = 1'b0;
        #1;
        n_total++;
        if (occ_map !== 8'h00 || full !== 1'b0 || occ_count !== 4'd0) $display("FAIL abort_async got map=%h cnt=%0d full=%b want 00/0/0", occ_map, occ_count, full); else n_pass++;
        acks = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (ex_ack || en_ack || rsp_valid) acks++;
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ex_ack || en_ack || rsp_valid) acks++;
        end
        n_total++;
        if (acks !== 0) $display("FAIL abort_no_ack got %0d ack cycles want 0", acks); else n_pass++;
        n_total++;
        if (occ_map !== 8'h00 || full !== 1'b0) $display("FAIL abort_map got map=%h full=%b want 00/0", occ_map, full); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_entry_ok();
        test_conflict();
        test_round_robin();
        test_bad_flat_pwd();
        test_full_and_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
